dmem_sized: RTL

- Parametrised, word-organised data memory for the siiCpu load/store path. Next generation of the flat byte-array memory.
- Adds byte/half/word access sizes with sign or zero extension, a selectable byte order, and a configurable number of wait states.
- Uses a valid/ready request handshake with a one-cycle response pulse, and flags misaligned accesses.
- Sits between the MEM stage (or bus arbiter) and on-chip RAM.

---
 rtl/dmem_sized_if.sv | 26 ++
 rtl/dmem_sized.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_sized_if.sv
// Request/response bundle between a load/store master and dmem_sized.
// Master drives the request fields; the memory drives ready and the response pulse.
interface dmem_sized_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sized.sv
// Word-organised data RAM with byte/half/word access, selectable endianness and wait states.
// Latency: accept edge + WAIT_CYCLES+1 edges to a one-cycle rsp_valid; no response backpressure.
module dmem_sized #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1,
  parameter bit BIG_ENDIAN  = 1
) (
  input  logic clk,
  input  logic rst_,
  dmem_sized_if.slave bus
);
  localparam int         DEPTH   = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_commit;
  logic              w_err;
  logic [1:0]        w_off;
  logic [ADDR_W-3:0] w_idx;
  logic [1:0]        w_byte_lane;
  logic              w_half_hi;
  logic [3:0]        w_be;
  logic [31:0]       w_wdat;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_rdata;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);

  assign w_off       = r_addr[1:0];
  assign w_idx       = r_addr[ADDR_W-1:2];
  assign w_byte_lane = BIG_ENDIAN ? (2'd3 - w_off) : w_off;
  assign w_half_hi   = BIG_ENDIAN ? ~w_off[1] : w_off[1];

  assign w_err = (r_size == 2'b11) ||
                 ((r_size == 2'b01) && w_off[0]) ||
                 ((r_size == 2'b10) && (w_off != 2'b00));

  // WAIT is always visited once, so accept-to-response is WAIT_CYCLES+1 edges even at zero waits.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= LP_WAIT;
      else if ((r_state == WAIT) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= bus.req_we;
      r_unsigned <= bus.req_unsigned;
      r_size     <= bus.req_size;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
    end
  end

  always_comb begin
    w_be   = 4'b0000;
    w_wdat = r_wdata;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << w_byte_lane;
        w_wdat = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_half_hi ? 4'b1100 : 4'b0011;
        w_wdat = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM body is deliberately left out of reset so it can map onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_byte_lane +: 8];
  assign w_half = w_half_hi ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = 32'd0;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_load = w_word;
      default: w_load = 32'd0;
    endcase
  end

  assign w_rdata = (r_we || w_err) ? 32'd0 : w_load;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= w_rdata;
      r_err   <= w_err;
    end else if (r_state == RESP) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule
